// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
// Defining MEM_ARB_FIXED_PRIO_EN switches arbitration from round-robin to fixed priority.
package mem_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: rotating priority starting after 'last', or,
// with MEM_ARB_FIXED_PRIO_EN defined, fixed priority with the lowest index first.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = ^last;

    // Lowest asserted index wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        win     = '0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                win[i]  = 1'b1;
                win_idx = IDX_W'(i);
            end else begin
                found = found;
            end
        end
    end
`else
    // Search last+1, last+2, ... modulo NREQ; first asserted request wins.
    always_comb begin
        logic found;
        int   cand;
        found   = 1'b0;
        cand    = 0;
        win     = '0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory among NREQ requesters, one access every three cycles.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          rw,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          gnt,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_valid,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    input  logic [DATA_W-1:0]        mem_dout
);

    localparam int IDX_W = idx_width(NREQ);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     win_s;
    logic [IDX_W-1:0]    win_idx_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
    mem_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .last    ({IDX_W{1'b0}}),
        .win     (win_s),
        .win_idx (win_idx_s)
    );
`else
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    mem_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .last    (last_q),
        .win     (win_s),
        .win_idx (win_idx_s)
    );

    // Round-robin pointer and the index of the current owner.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q <= IDX_W'(NREQ - 1);
            idx_q  <= '0;
        end else begin
            last_q <= last_d;
            idx_q  <= idx_d;
        end
    end

    // Owner index is captured at grant and becomes the pointer when the access retires.
    always_comb begin
        last_d = last_q;
        idx_d  = idx_q;
        if (state_q == ST_IDLE && (|req)) begin
            idx_d = win_idx_s;
        end else if (state_q == ST_RESP) begin
            last_d = idx_q;
        end else begin
            idx_d = idx_q;
        end
    end
`endif

    // FSM state and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic; the winning request is latched once and inputs are ignored afterwards.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        busy_d      = busy_q;
        mem_valid_d = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_ISSUE;
                    gnt_d       = win_s;
                    busy_d      = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_rw_d    = rw[win_idx_s];
                    mem_addr_d  = addr[win_idx_s*ADDR_W +: ADDR_W];
                    mem_din_d   = wdata[win_idx_s*DATA_W +: DATA_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                ack_d   = gnt_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                if (!mem_rw_q) begin
                    rdata_d = mem_dout;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The memory loads D_OUT on the edge entering RESP, so read data is steered straight
    // from it while ack is high and held in rdata_q otherwise.
    assign rdata     = (state_q == ST_RESP && !mem_rw_q) ? mem_dout : rdata_q;
    assign ack       = ack_q;
    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory and a transaction-level model.
module tb_mem_arbiter;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   rw = '0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [3:0]   ack, gnt;
    logic [31:0]  rdata, mem_din, mem_dout;
    logic         busy, mem_valid, mem_rw;
    logic [7:0]   mem_addr;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.NREQ(4), .ADDR_W(8), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .ack(ack), .gnt(gnt), .rdata(rdata), .busy(busy), .mem_valid(mem_valid),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Synchronous single-port memory sharing RESET.
    logic [31:0] tb_mem [256];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_dout <= '0;
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
        end else if (mem_valid) begin
            if (mem_rw) tb_mem[mem_addr] <= mem_din;
            else        mem_dout <= tb_mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return 0;
    endfunction

    // Transaction-level model: phase 0 = waiting, 1 = access on the memory bus, 2 = acknowledging.
    int          m_phase = 0, m_w = 0, m_last = 3;
    logic        m_rw = 1'b0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_din = '0, m_rdata = '0;
    logic [31:0] m_mem [256];

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_phase <= 0; m_w <= 0; m_last <= 3; m_rw <= 1'b0;
            m_addr <= '0; m_din <= '0; m_rdata <= '0;
            for (int i = 0; i < 256; i++) m_mem[i] <= '0;
        end else begin
            case (m_phase)
                0: if (req != 4'b0000) begin
                    m_w     <= pick(req, m_last);
                    m_rw    <= rw[pick(req, m_last)];
                    m_addr  <= addr[pick(req, m_last)*8 +: 8];
                    m_din   <= wdata[pick(req, m_last)*32 +: 32];
                    m_phase <= 1;
                end
                1: begin
                    if (m_rw) m_mem[m_addr] <= m_din;
                    else      m_rdata <= m_mem[m_addr];
                    m_phase <= 2;
                end
                default: begin
                    m_last  <= m_w;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("gnt",   gnt,   (m_phase != 0) ? (4'b0001 << m_w) : 4'b0000);
            chk("ack",   ack,   (m_phase == 2) ? (4'b0001 << m_w) : 4'b0000);
            chk("busy",  busy,  m_phase != 0);
            chk("mem_valid", mem_valid, m_phase == 1);
            chk("rdata", rdata, m_rdata);
            if (m_phase == 1) begin
                chk("mem_rw",   mem_rw,   m_rw);
                chk("mem_addr", mem_addr, m_addr);
                if (m_rw) chk("mem_din", mem_din, m_din);
            end
        end
    end

    task automatic set_req(input int i, input logic r, input logic [7:0] a, input logic [31:0] d);
        req[i] = 1'b1;
        rw[i] = r;
        addr[i*8 +: 8] = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_bit(input int i, input logic use_gnt, output int cyc, output logic [31:0] data);
        cyc = -1;
        data = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if ((use_gnt ? gnt[i] : ack[i]) === 1'b1) begin
                cyc = c;
                data = rdata;
                break;
            end
        end
        if (cyc < 0) chk("wait_timeout", 64'(i), 64'hFFFF);
    endtask

    int left [4];
    int ord_q[$];
    logic [31:0] dat_q[$];

    // Requester i keeps its request up until left[i] acks have arrived.
    task automatic run_multi(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (left[0] + left[1] + left[2] + left[3] == 0) break;
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && left[i] > 0) begin
                    ord_q.push_back(i);
                    dat_q.push_back(rdata);
                    left[i]--;
                    if (left[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (left[0] + left[1] + left[2] + left[3] != 0) chk("multi_timeout", 64'(left[0] + left[1] + left[2] + left[3]), 64'd0);
    endtask

    task automatic do_reset();
        #2 RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    logic [31:0] pre [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    int exp_ord4 [4];
    int cyc;
    logic [31:0] d;
    int ones;

    initial begin
        // Reset state
        @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_outs", {ack, gnt, busy, mem_valid, mem_rw, mem_addr}, 64'd0);
        chk("rst_data", {rdata, mem_din}, 64'd0);
        RESET = 1'b0;
        ones = 0;
        repeat (10) begin
            @(negedge CLK);
            ones += int'(mem_valid);
        end
        chk("idle_valid", 64'(ones), 64'd0);

        // Single write then read through requester 0
        set_req(0, 1'b1, 8'h00, 32'hACBD4432);
        wait_bit(0, 1'b0, cyc, d);
        req[0] = 1'b0;
        chk("wr_latency", 64'(cyc), 64'd2);
        set_req(0, 1'b0, 8'h00, 32'h0);
        wait_bit(0, 1'b0, cyc, d);
        req[0] = 1'b0;
        chk("rd_data", d, 32'hACBD4432);

        // Contention: preload through requester 3 so the pointer ends on 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(3, 1'b1, 8'(8'h10 + i), pre[i]);
            wait_bit(3, 1'b0, cyc, d);
            req[3] = 1'b0;
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h10 + i), 32'h0);
        left = '{2, 1, 1, 1};
        ord_q.delete(); dat_q.delete();
        run_multi(60);
        exp_ord4 = '{0, 1, 2, 3};
        for (int k = 0; k < 5 && k < ord_q.size(); k++) begin
            chk("contend_order", 64'(ord_q[k]), 64'(exp_ord4[k % 4]));
            chk("contend_data", dat_q[k], pre[exp_ord4[k % 4]]);
        end
        chk("contend_count", 64'(ord_q.size()), 64'd5);

        // Fairness between requesters 1 and 3
        @(negedge CLK);
        set_req(1, 1'b0, 8'h11, 32'h0);
        set_req(3, 1'b0, 8'h13, 32'h0);
        left = '{0, 2, 0, 2};
        ord_q.delete(); dat_q.delete();
        run_multi(60);
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_ord4 = '{1, 1, 3, 3};
`else
        exp_ord4 = '{1, 3, 1, 3};
`endif
        for (int k = 0; k < 4 && k < ord_q.size(); k++) begin
            chk("fair_order", 64'(ord_q[k]), 64'(exp_ord4[k]));
            chk("fair_data", dat_q[k], pre[exp_ord4[k]]);
        end

        // Request dropped while the access is on the bus
        @(negedge CLK);
        set_req(2, 1'b1, 8'h04, 32'hDFD6BB42);
        wait_bit(2, 1'b1, cyc, d);
        req[2] = 1'b0;
        wait_bit(2, 1'b0, cyc, d);
        chk("drop_ack", 64'(cyc > 0), 64'd1);
        set_req(1, 1'b0, 8'h04, 32'h0);
        wait_bit(1, 1'b0, cyc, d);
        req[1] = 1'b0;
        chk("drop_rd", d, 32'hDFD6BB42);

        // Reset while ISSUE is on the bus
        @(negedge CLK);
        set_req(1, 1'b0, 8'h10, 32'h0);
        wait_bit(1, 1'b1, cyc, d);
        set_req(0, 1'b0, 8'h11, 32'h0);
        #2 RESET = 1'b1;
        #1 chk("rst_mid", {ack, gnt, busy, mem_valid}, 64'd0);
        @(negedge CLK);
        chk("rst_mid_ack", ack, 4'b0000);
        RESET = 1'b0;
        left = '{1, 1, 0, 0};
        ord_q.delete(); dat_q.delete();
        run_multi(30);
        if (ord_q.size() > 0) chk("rst_first", 64'(ord_q[0]), 64'd0);
        if (dat_q.size() > 0) chk("rst_cleared", dat_q[0], 32'h0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && req[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
                end else if (gnt[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        repeat (8) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
